// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol phase encoding, ACK levels, field widths
// and a wrapping register-address increment.
package i2c_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int CHIP_ID_W  = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_e;

    // Register address step; wraps 0xFF -> 0x00 by natural overflow.
    function automatic logic [REG_ADDR_W-1:0] reg_addr_next(input logic [REG_ADDR_W-1:0] addr);
        return addr + {{(REG_ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Register-file side of the I2C target: address, write strobe/data,
// read request and the read word returned by the user register file.
interface i2c_target_regfile_if #(
    parameter int DATA_BYTES = 2
);
    logic [7:0]              reg_addr;
    logic                    wr_en;
    logic [8*DATA_BYTES-1:0] wr_data;
    logic                    rd_en;
    logic [8*DATA_BYTES-1:0] rd_data;

    modport master (output reg_addr, output wr_en, output wr_data, output rd_en, input rd_data);
    modport slave  (input reg_addr, input wr_en, input wr_data, input rd_en, output rd_data);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SDA/SCL into the clk domain and produces registered
// one-clock strobes for SCL edges and START/STOP conditions, plus the
// SDA level seen at the same instant as those strobes.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sda_in,
    input  logic scl_in,
    output logic sda_bit,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic sda_prev_q, scl_prev_q;
    logic sda_s, scl_s;
    logic sda_bit_q, sda_bit_d;
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;

    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign scl_s = scl_sync_q[SYNC_STAGES-1];

    // Shift chains and edge/condition decode from the settled line levels.
    always_comb begin
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_bit_d  = sda_s;
        scl_rise_d = scl_s & ~scl_prev_q;
        scl_fall_d = ~scl_s & scl_prev_q;
        start_d    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
        stop_d     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
    end

    // Synchronizer flops; lines reset to the idle-high bus level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_prev_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_bit_q  <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            sda_sync_q <= sda_sync_d;
            scl_sync_q <= scl_sync_d;
            sda_prev_q <= sda_s;
            scl_prev_q <= scl_s;
            sda_bit_q  <= sda_bit_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_bit   = sda_bit_q;
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target serving a 256-entry register space: chip-ID match, one
// register-address byte, then auto-incrementing word writes or reads.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter int DATA_BYTES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CHIP_ID_W-1:0] chip_id,
    input  logic                 sda_in,
    input  logic                 scl_in,
    output logic                 sda_out,
    output logic                 sda_oen,
    output logic                 scl_out,
    output logic                 scl_oen,
    output logic                 busy,
    output logic                 done,
    i2c_target_regfile_if.master rf
);
    localparam int WORD_W     = 8 * DATA_BYTES;
    localparam int BYTE_CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DATA_BYTES - 1);

    logic sda_bit, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .reset(reset), .sda_in(sda_in), .scl_in(scl_in),
        .sda_bit(sda_bit), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det)
    );

    i2c_state_e              state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [WORD_W-1:0]       wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sda_oen_q, sda_oen_d;
    logic                    rw_q, rw_d;
    logic                    byte_end;
    logic                    id_match;

    // The SCL fall closing the 8th bit hands the bus to the ACK slot.
    assign byte_end = scl_fall && (bit_cnt_q == 4'd8);
    assign id_match = (shift_q[7:1] == chip_id);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable and STOP/START override the protocol phase.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:      state_d = byte_end ? (id_match ? ST_ADDR_ACK : ST_WAIT_STOP) : state_q;
                ST_ADDR_ACK:  state_d = scl_fall ? (rw_q ? ST_RDATA : ST_REG) : state_q;
                ST_REG:       state_d = byte_end ? ST_REG_ACK : state_q;
                ST_REG_ACK:   state_d = scl_fall ? ST_WDATA : state_q;
                ST_WDATA:     state_d = byte_end ? ST_WDATA_ACK : state_q;
                ST_WDATA_ACK: state_d = scl_fall ? ST_WDATA : state_q;
                ST_RDATA:     state_d = byte_end ? ST_RDATA_ACK : state_q;
                ST_RDATA_ACK: begin
                    if (scl_rise && (sda_bit == NACK)) begin
                        state_d = ST_WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d = ST_RDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: state_d = state_q;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: shifting, ACK drive, strobes and address counter.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sda_oen_d  = sda_oen_q;
        rw_d       = rw_q;
        if (!enable) begin
            bit_cnt_d  = 4'd0;
            byte_cnt_d = '0;
            shift_d    = '0;
            reg_addr_d = '0;
            wr_data_d  = '0;
            busy_d     = 1'b0;
            sda_oen_d  = 1'b1;
            rw_d       = 1'b0;
        end else if (stop_det) begin
            done_d     = busy_q;
            busy_d     = 1'b0;
            sda_oen_d  = 1'b1;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = '0;
        end else if (start_det) begin
            sda_oen_d  = 1'b1;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = '0;
        end else begin
            if (wr_en_q) begin
                reg_addr_d = reg_addr_next(reg_addr_q);
            end else begin
                reg_addr_d = reg_addr_q;
            end
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise && (bit_cnt_q < 4'd8)) begin
                        shift_d   = {shift_q[WORD_W-2:0], sda_bit};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_end) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            rw_d = shift_q[0];
                            if (id_match) begin
                                sda_oen_d = ACK;
                                busy_d    = 1'b1;
                                rd_en_d   = shift_q[0];
                            end else begin
                                sda_oen_d = 1'b1;
                            end
                        end else begin
                            sda_oen_d = ACK;
                            if (state_q == ST_REG) begin
                                reg_addr_d = shift_q[REG_ADDR_W-1:0];
                            end else begin
                                reg_addr_d = reg_addr_q;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = '0;
                        sda_oen_d  = (state_q == ST_ADDR_ACK && rw_q) ? shift_q[WORD_W-1] : 1'b1;
                    end else begin
                        sda_oen_d  = sda_oen_q;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_rise) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = shift_q;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        sda_oen_d = 1'b1;
                    end else begin
                        sda_oen_d = sda_oen_q;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && (bit_cnt_q < 4'd8)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q != 4'd0)) begin
                        // Shifting on the 8th fall too leaves the next byte's MSB on top.
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        if (byte_end) begin
                            sda_oen_d = 1'b1;
                            bit_cnt_d = 4'd0;
                        end else begin
                            sda_oen_d = shift_q[WORD_W-2];
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && (sda_bit == ACK)) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            reg_addr_d = reg_addr_next(reg_addr_q);
                            rd_en_d    = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        sda_oen_d = shift_q[WORD_W-1];
                    end else begin
                        sda_oen_d = sda_oen_q;
                    end
                end
                default: begin
                    sda_oen_d = 1'b1;
                end
            endcase
            // Read word arrives exactly one clk after the request.
            if (rd_en_q) begin
                shift_d = rf.rd_data;
            end else begin
                shift_d = shift_d;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sda_oen_q  <= 1'b1;
            rw_q       <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sda_oen_q  <= sda_oen_d;
            rw_q       <= rw_d;
        end
    end

    assign sda_out     = 1'b0;
    assign scl_out     = 1'b0;
    assign scl_oen     = 1'b1;
    assign sda_oen     = sda_oen_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rf.reg_addr = reg_addr_q;
    assign rf.wr_en    = wr_en_q;
    assign rf.wr_data  = wr_data_q;
    assign rf.rd_en    = rd_en_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-level I2C controller drives the bus,
// a register-file array answers reads, and expectations come from the
// transaction-level address/data rules.
module tb_i2c_target_regfile;

    localparam int Q = 5;   // quarter SCL period in clk cycles

    logic       clk;
    logic       reset;
    logic       enable;
    logic [6:0] chip_id_r;
    logic       sda_c;
    logic       scl;
    logic       sda_line;
    logic       sda_out, sda_oen, scl_out, scl_oen, busy, done;

    logic [15:0] rf_mem [256];
    logic [7:0]  wr_addr_log [$];
    logic [15:0] wr_data_log [$];
    logic [7:0]  rd_addr_log [$];
    int          done_cnt;
    int          busy_cnt;
    int          n_vec;
    int          n_err;
    logic [7:0]  model_addr;
    logic [15:0] wdat [8];

    i2c_target_regfile_if #(.DATA_BYTES(2)) rf_if ();

    assign sda_line      = sda_c & sda_oen;
    assign rf_if.rd_data = rf_mem[rf_if.reg_addr];

    i2c_target_regfile #(.DATA_BYTES(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .chip_id(chip_id_r),
        .sda_in(sda_line), .scl_in(scl),
        .sda_out(sda_out), .sda_oen(sda_oen), .scl_out(scl_out), .scl_oen(scl_oen),
        .busy(busy), .done(done), .rf(rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log strobes away from the active edge.
    always @(negedge clk) begin
        if (rf_if.wr_en) begin
            wr_addr_log.push_back(rf_if.reg_addr);
            wr_data_log.push_back(rf_if.wr_data);
        end
        if (rf_if.rd_en) rd_addr_log.push_back(rf_if.reg_addr);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_c = b;    wclk(Q);
        scl   = 1'b1; wclk(Q);
        s     = sda_line; wclk(Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; wclk(Q);
        scl   = 1'b1; wclk(2*Q);
        sda_c = 1'b0; wclk(2*Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; wclk(Q);
        scl   = 1'b1; wclk(2*Q);
        sda_c = 1'b1; wclk(2*Q);
    endtask

    task automatic wr_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] v);
        logic s;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            v = {v[6:0], s};
        end
        bus_bit(ack, s);
    endtask

    // Write nw words from wdat[] starting at register ra to chip id.
    task automatic wr_txn(input logic [6:0] id, input logic [7:0] ra, input int nw);
        int   wb = wr_addr_log.size();
        int   rb = rd_addr_log.size();
        int   db = done_cnt;
        int   bb = busy_cnt;
        logic a;
        i2c_start();
        wr_byte({id, 1'b0}, a);
        if (id == chip_id_r) begin
            chk("addr_ack", a, 1'b0);
            chk("busy_in_txn", busy, 1'b1);
            wr_byte(ra, a);
            chk("reg_ack", a, 1'b0);
            for (int i = 0; i < nw; i++) begin
                for (int b = 0; b < 2; b++) begin
                    wr_byte(wdat[i][15-8*b -: 8], a);
                    chk("data_ack", a, 1'b0);
                end
            end
            i2c_stop();
            model_addr = 8'(ra + nw);
            chk("wr_count", wr_addr_log.size() - wb, nw);
            for (int i = 0; i < nw && (wb + i) < wr_addr_log.size(); i++) begin
                chk("wr_addr", wr_addr_log[wb+i], 8'(ra + i));
                chk("wr_data", wr_data_log[wb+i], wdat[i]);
            end
            chk("wr_done", done_cnt - db, 1);
        end else begin
            chk("addr_nack", a, 1'b1);
            i2c_stop();
            chk("nomatch_wr", wr_addr_log.size() - wb, 0);
            chk("nomatch_rd", rd_addr_log.size() - rb, 0);
            chk("nomatch_done", done_cnt - db, 0);
            chk("nomatch_busy", busy_cnt - bb, 0);
        end
        wclk(2);
        chk("reg_addr_after_wr", rf_if.reg_addr, model_addr);
    endtask

    // Set register ra, repeated START, read nw words, NACK the last byte.
    task automatic rd_txn(input logic [7:0] ra, input int nw);
        int         rb = rd_addr_log.size();
        int         db = done_cnt;
        logic       a;
        logic [7:0] v;
        logic [15:0] w;
        i2c_start();
        wr_byte({chip_id_r, 1'b0}, a);
        chk("rd_waddr_ack", a, 1'b0);
        wr_byte(ra, a);
        chk("rd_reg_ack", a, 1'b0);
        i2c_start();
        wr_byte({chip_id_r, 1'b1}, a);
        chk("rd_raddr_ack", a, 1'b0);
        for (int i = 0; i < nw; i++) begin
            w = rf_mem[8'(ra + i)];
            for (int b = 0; b < 2; b++) begin
                rd_byte((i == nw - 1 && b == 1) ? 1'b1 : 1'b0, v);
                chk("rd_byte", v, w[15-8*b -: 8]);
            end
        end
        i2c_stop();
        model_addr = 8'(ra + nw - 1);
        chk("rd_count", rd_addr_log.size() - rb, nw);
        for (int i = 0; i < nw && (rb + i) < rd_addr_log.size(); i++) begin
            chk("rd_addr", rd_addr_log[rb+i], 8'(ra + i));
        end
        chk("rd_done", done_cnt - db, 1);
        wclk(2);
        chk("reg_addr_after_rd", rf_if.reg_addr, model_addr);
    endtask

    initial begin
        logic a, s;
        int   wb, db;
        n_vec = 0; n_err = 0; done_cnt = 0; busy_cnt = 0;
        model_addr = 8'h00;
        for (int i = 0; i < 256; i++) rf_mem[i] = 16'($urandom);
        reset = 1'b0; enable = 1'b1; chip_id_r = 7'h0F;
        sda_c = 1'b1; scl = 1'b1;
        wclk(5);
        reset = 1'b1;
        wclk(5);

        // Reset state
        chk("rst_sda_oen", sda_oen, 1'b1);
        chk("rst_reg_addr", rf_if.reg_addr, 8'h00);
        chk("rst_wr_en", rf_if.wr_en, 1'b0);
        chk("rst_wr_data", rf_if.wr_data, 16'h0000);
        chk("rst_rd_en", rf_if.rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("const_sda_out", sda_out, 1'b0);
        chk("const_scl_out", scl_out, 1'b0);
        chk("const_scl_oen", scl_oen, 1'b1);

        // Single word write
        wdat[0] = 16'hB2B2;
        wr_txn(7'h0F, 8'h0A, 1);

        // Burst write wrapping the register address
        wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333;
        wr_txn(7'h0F, 8'hFE, 3);

        // Address mismatch
        wr_txn(7'h10, 8'h55, 1);

        // Write-register then repeated-START read of two words
        rf_mem[8'h1A] = 16'hD4D4; rf_mem[8'h1B] = 16'hC3C3;
        rd_txn(8'h1A, 2);

        // STOP after the first data byte discards the partial word
        wb = wr_addr_log.size(); db = done_cnt;
        i2c_start();
        wr_byte({chip_id_r, 1'b0}, a);
        wr_byte(8'h33, a);
        wr_byte(8'h9C, a);
        i2c_stop();
        model_addr = 8'h33;
        chk("partial_no_wr", wr_addr_log.size() - wb, 0);
        chk("partial_done", done_cnt - db, 1);
        chk("partial_reg_addr", rf_if.reg_addr, model_addr);
        wdat[0] = 16'h5AA5;
        wr_txn(7'h0F, 8'h34, 1);

        // Randomized write/read traffic
        for (int it = 0; it < 4; it++) begin
            int nw = int'($urandom_range(1, 3));
            for (int i = 0; i < nw; i++) wdat[i] = 16'($urandom);
            wr_txn(chip_id_r, 8'($urandom), nw);
            rd_txn(8'($urandom), int'($urandom_range(1, 3)));
        end

        // Reset asserted mid-byte during a read while SDA is pulled low
        rf_mem[8'h40] = 16'h0000;
        i2c_start();
        wr_byte({chip_id_r, 1'b0}, a);
        wr_byte(8'h40, a);
        i2c_start();
        wr_byte({chip_id_r, 1'b1}, a);
        chk("mid_rd_ack", a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus_bit(1'b1, s);
            chk("mid_rd_bit", s, 1'b0);
        end
        chk("mid_rd_driving", sda_oen, 1'b0);
        reset = 1'b0;
        #1;
        chk("async_rst_sda_oen", sda_oen, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_reg_addr", rf_if.reg_addr, 8'h00);
        chk("async_rst_rd_en", rf_if.rd_en, 1'b0);
        chk("async_rst_wr_en", rf_if.wr_en, 1'b0);
        chk("async_rst_done", done, 1'b0);
        sda_c = 1'b1; scl = 1'b1;
        wclk(4);
        reset = 1'b1;
        wclk(4);
        model_addr = 8'h00;
        wdat[0] = 16'hE71C;
        wr_txn(7'h0F, 8'h77, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Standalone I2C target (responder) that serves a 256-entry, 16-bit register space to an external I2C controller. It samples SDA/SCL on the system clock, detects START/STOP, matches a 7-bit chip ID, and takes one register-address byte. It then either emits register-write strobes or fetches register-read words, with the address auto-incrementing per word. It sits between the open-drain pad drivers and a user register file. It is the bus-level responder counterpart to the controller-side i2c core used by the block-write bench.

## Interface
- DATA_BYTES, 2, bytes per register word, MSB byte first; word width = 8*DATA_BYTES
- SYNC_STAGES, 2, synchronizer flops on sda_in/scl_in (min 2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = respond on bus; 0 = idle, bus released
- chip_id  in  7  target address to match
- sda_in, scl_in  in  1  bus lines (after pad)
- sda_out  out  1  constant 0 (open-drain data)
- sda_oen  out  1  0 = pull SDA low, 1 = release; reset 1
- scl_out  out  1  constant 0; scl_oen  out  1  constant 1 (no clock stretching)
- reg_addr  out  8  current register address; reset 0x00
- wr_en  out  1  one-clk write strobe; reset 0
- wr_data  out  8*DATA_BYTES  word for wr_en; reset 0
- rd_en  out  1  one-clk read request; reset 0
- rd_data  in  8*DATA_BYTES  must be valid on the clk edge after rd_en
- busy  out  1  high from address match to STOP/abort; reset 0
- done  out  1  one-clk pulse at STOP ending an addressed transaction; reset 0

## Operation
- Bus events use synchronized lines only. START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Bit sample: SCL rise. Drive change: SCL fall.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE→ADDR on START. After 8 bits, if addr[7:1]==chip_id go to ADDR_ACK. Otherwise go to WAIT_STOP with SDA released (NACK).
- ADDR_ACK: drive SDA low from the SCL fall after bit 8 until the next SCL fall. Set busy. R/W=0 → REG; R/W=1 → RDATA.
- REG: 8 bits load reg_addr, then REG_ACK, then WDATA.
- WDATA: shift bytes. ACK each byte. After the ACK of the last byte of a word, pulse wr_en with the assembled wr_data and the current reg_addr. Increment reg_addr on the next clk, wrapping 0xFF→0x00.
- RDATA: pulse rd_en on entry to ADDR_ACK, capture rd_data one clk later into the shift register, and shift MSB first on SCL falls. RDATA_ACK samples the controller ACK. ACK=0 continues to the next byte. At a word boundary, increment reg_addr, pulse rd_en, and capture. NACK → WAIT_STOP.
- Repeated START from any state → ADDR. reg_addr is retained, so write-reg then read works.
- STOP from any state → IDLE, SDA released. done pulses if busy was set. A partial write word is discarded with no wr_en.
- enable=0 or reset: immediate return to IDLE. All outputs take their reset values. An in-flight word is dropped.

## Timing
- Input latency: SYNC_STAGES+1 clk from pad to event detect.
- SCL high and low phases must each be ≥ SYNC_STAGES+4 clk; slower buses are unconstrained.
- wr_en: 1 clk after the SCL rise that samples the controller-side 9th bit, i.e. the ACK clock of the last byte.
- rd_en to capture: exactly 1 clk. The MSB is on SDA before the following SCL rise.
- STOP to done: 1 clk after STOP detect. busy falls on the same clk.
- Simultaneous wr_en and STOP is impossible, since STOP only follows an ACK clock. If STOP arrives mid-byte, the byte is discarded.

## Structure
- Package i2c_pkg: state enum, ACK=1'b0 / NACK=1'b1, REG_ADDR_W=8, CHIP_ID_W=7. Shared with the controller core.
- Sub-module i2c_bus_sync: synchronizers, SCL rise/fall strobes, START/STOP strobes.
- Top: FSM, bit counter (0..8), byte counter (0..DATA_BYTES-1), shift register, reg_addr counter.

## Test plan
- Write chip 0x0F, reg 0x0A, data 0xB2B2, STOP → one wr_en with reg_addr=0x0A and wr_data=0xB2B2; ACK on all 4 bytes; one done pulse.
- Burst write reg 0xFE with words 0x1111, 0x2222, 0x3333 → wr_en at 0xFE, 0xFF, 0x00 (wrap).
- Address chip 0x10 while chip_id=0x0F → SDA released on 9th clock; no wr_en, rd_en, busy, or done.
- Write reg 0x1A, repeated START, read 2 words with regfile returning 0xD4D4 then 0xC3C3, final NACK → bus bytes D4 D4 C3 C3; rd_en at 0x1A and 0x1B.
- STOP after the first data byte of a write → no wr_en; done pulses; next transaction is normal.
- reset low mid-byte during a read → sda_oen=1 within the same clk; all outputs at reset values; next write is accepted.
